// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and default bit timing for the UART receiver.
package uart_pkg;

  localparam int ClksPerBitDefault = 868;

  // PARITY is only reachable when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input, resets to 1.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver feeding a fifo write port; even parity via UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClksPerBit = ClksPerBitDefault,
  parameter int DataWidth  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  input  logic                 i_full,
  output logic [DataWidth-1:0] o_wr_data,
  output logic                 o_wr_en,
  output logic                 o_frame_err,
  output logic                 o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 o_parity_err,
`endif
  output logic                 o_busy
);

  localparam int BW = $clog2(ClksPerBit);
  localparam int IW = $clog2(DataWidth + 1);
  localparam logic [BW-1:0] BitLast  = BW'(ClksPerBit - 1);
  localparam logic [BW-1:0] HalfLast = BW'(ClksPerBit / 2 - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DataWidth - 1);

  rx_state_e            state, state_nxt;
  logic [BW-1:0]        bit_ctr, bit_nxt;
  logic [IW-1:0]        idx_ctr, idx_nxt;
  logic [DataWidth-1:0] shift_reg, shift_nxt;
  logic [DataWidth-1:0] wr_data_nxt;
  logic                 wr_en_nxt, frame_err_nxt, overrun_nxt;
  logic                 rx_s, rx_prev, fall;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_nxt, parity_err_nxt;
`endif

  sync_2ff u_sync (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (i_rx),
    .q    (rx_s)
  );

  assign fall   = rx_prev & ~rx_s;
  assign o_busy = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    bit_nxt       = bit_ctr;
    idx_nxt       = idx_ctr;
    shift_nxt     = shift_reg;
    wr_data_nxt   = o_wr_data;
    wr_en_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt    = par_bad;
    parity_err_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          bit_nxt   = '0;
        end
      end
      START: begin
        // Half-bit check rejects short low glitches and aligns later samples to mid-bit.
        if (bit_ctr == HalfLast) begin
          bit_nxt = '0;
          idx_nxt = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          bit_nxt = bit_ctr + BW'(1);
        end
      end
      DATA: begin
        if (bit_ctr == BitLast) begin
          bit_nxt   = '0;
          idx_nxt   = idx_ctr + IW'(1);
          shift_nxt = {rx_s, shift_reg[DataWidth-1:1]};
          if (idx_ctr == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          bit_nxt = bit_ctr + BW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_ctr == BitLast) begin
          bit_nxt     = '0;
          par_bad_nxt = (^shift_reg) ^ rx_s;
          state_nxt   = STOP;
        end else begin
          bit_nxt = bit_ctr + BW'(1);
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (bit_ctr == BitLast) begin
          bit_nxt = '0;
          if (!rx_s) begin
            frame_err_nxt = 1'b1;
            state_nxt     = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            parity_err_nxt = 1'b1;
            state_nxt      = IDLE;
`endif
          end else if (i_full) begin
            overrun_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            wr_en_nxt   = 1'b1;
            wr_data_nxt = shift_reg;
            state_nxt   = IDLE;
          end
        end else begin
          bit_nxt = bit_ctr + BW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      bit_ctr     <= '0;
      idx_ctr     <= '0;
      shift_reg   <= '0;
      rx_prev     <= 1'b1;
      o_wr_data   <= '0;
      o_wr_en     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      bit_ctr     <= bit_nxt;
      idx_ctr     <= idx_nxt;
      shift_reg   <= shift_nxt;
      rx_prev     <= rx_s;
      o_wr_data   <= wr_data_nxt;
      o_wr_en     <= wr_en_nxt;
      o_frame_err <= frame_err_nxt;
      o_overrun   <= overrun_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad      <= par_bad_nxt;
      o_parity_err <= parity_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int Cpb = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBits = 10;
`else
  localparam int NBits = 9;
`endif
  // Start-edge to strobe: mid-point of the stop bit plus 3 cycles.
  localparam int Lat = NBits * Cpb + Cpb / 2 + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       full;
  logic [7:0] wr_data;
  logic       wr_en, frame_err, overrun, busy;
  logic       parity_err;

  uart_rx #(.ClksPerBit(Cpb), .DataWidth(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .i_full      (full),
    .o_wr_data   (wr_data),
    .o_wr_en     (wr_en),
    .o_frame_err (frame_err),
    .o_overrun   (overrun),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(parity_err),
`endif
    .o_busy      (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_wr = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, last_ev = 0;
  logic [7:0] wr_q[$];
  always @(negedge clk) begin
    if (wr_en) begin n_wr <= n_wr + 1; wr_q.push_back(wr_data); last_ev <= cyc; end
    if (frame_err) begin n_ferr <= n_ferr + 1; last_ev <= cyc; end
    if (overrun) begin n_ovr <= n_ovr + 1; last_ev <= cyc; end
    if (parity_err) begin n_perr <= n_perr + 1; last_ev <= cyc; end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // par < 0 sends the correct even-parity bit; hold_low leaves the line low after a bad stop.
  task automatic send(input logic [7:0] d, input logic stop, input int par,
                      input bit hold_low, output int t0);
    t0 = cyc;
    rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(Cpb);
    end
`ifdef UART_RX_PARITY_EN
    rx = (par < 0) ? ^d : par[0];
    tick(Cpb);
`else
    if (par > 1) $display("parity argument ignored");
`endif
    rx = stop;
    tick(Cpb);
    if (!hold_low) rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       full;
    int         exp_wr;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t0, w0, f0, o0, p0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0, 0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 0, 0, 1};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 0, 1, 0};
    vecs[5] = '{8'hC3, 1'b1, 1'b0, 1, 0, 0};

    rst_n = 1'b0;
    rx    = 1'b1;
    full  = 1'b0;
    tick(3);
    check("reset busy", busy, 0);
    check("reset wr_en", wr_en, 0);
    check("reset wr_data", wr_data, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    rst_n = 1'b1;
    tick(100);
    check("idle busy", busy, 0);
    check("idle strobes", n_wr + n_ferr + n_ovr + n_perr, 0);

    foreach (vecs[k]) begin
      w0 = n_wr; f0 = n_ferr; o0 = n_ovr;
      full = vecs[k].full;
      send(vecs[k].data, vecs[k].stop, -1, 1'b0, t0);
      full = 1'b0;
      tick(20);
      check($sformatf("vec%0d wr count", k), n_wr - w0, vecs[k].exp_wr);
      check($sformatf("vec%0d frame_err count", k), n_ferr - f0, vecs[k].exp_ferr);
      check($sformatf("vec%0d overrun count", k), n_ovr - o0, vecs[k].exp_ovr);
      check($sformatf("vec%0d latency", k), last_ev - t0, Lat);
      if (vecs[k].exp_wr == 1 && wr_q.size() > 0)
        check($sformatf("vec%0d wr_data", k), wr_q[$], vecs[k].data);
      check($sformatf("vec%0d busy after", k), busy, 0);
    end

    // Back-to-back frames with no idle gap.
    w0 = n_wr;
    send(8'h3C, 1'b1, -1, 1'b0, t0);
    send(8'hFF, 1'b1, -1, 1'b0, t0);
    tick(20);
    check("b2b wr count", n_wr - w0, 2);
    if (wr_q.size() >= 2) begin
      check("b2b first", wr_q[wr_q.size()-2], 8'h3C);
      check("b2b second", wr_q[$], 8'hFF);
    end

    // 4-cycle low glitch, then a real frame.
    w0 = n_wr; f0 = n_ferr;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(12);
    check("glitch busy", busy, 0);
    check("glitch strobes", (n_wr - w0) + (n_ferr - f0), 0);
    send(8'h12, 1'b1, -1, 1'b0, t0);
    tick(20);
    check("post-glitch wr count", n_wr - w0, 1);
    check("post-glitch data", wr_q[$], 8'h12);

    // Break: bad stop then line held low 40 more cycles.
    w0 = n_wr; f0 = n_ferr;
    send(8'h55, 1'b0, -1, 1'b1, t0);
    tick(30);
    check("break busy held", busy, 1);
    check("break frame_err", n_ferr - f0, 1);
    tick(10);
    rx = 1'b1;
    tick(6);
    check("break busy released", busy, 0);
    check("break single frame_err", n_ferr - f0, 1);
    check("break no write", n_wr - w0, 0);

    // Reset in the middle of a frame.
    w0 = n_wr;
    rx = 1'b0;
    tick(40);
    check("midframe busy", busy, 1);
    rst_n = 1'b0;
    tick(2);
    check("midframe reset busy", busy, 0);
    rx = 1'b1;
    rst_n = 1'b1;
    tick(5);
    send(8'h6B, 1'b1, -1, 1'b0, t0);
    tick(20);
    check("post-reset wr count", n_wr - w0, 1);
    check("post-reset data", wr_q[$], 8'h6B);

`ifdef UART_RX_PARITY_EN
    w0 = n_wr; p0 = n_perr;
    send(8'h07, 1'b1, 0, 1'b0, t0);
    tick(20);
    check("parity_err pulse", n_perr - p0, 1);
    check("parity_err latency", last_ev - t0, Lat);
    check("parity no write", n_wr - w0, 0);
    p0 = n_perr; f0 = n_ferr;
    send(8'h07, 1'b0, 0, 1'b0, t0);
    tick(20);
    check("parity+stop frame_err", n_ferr - f0, 1);
    check("parity+stop no parity_err", n_perr - p0, 0);
`else
    p0 = n_perr;
    check("no parity_err", n_perr - p0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive front end that deserialises the asynchronous serial line into DataWidth-bit words.
- Pushes each word into the downstream receive fifo through its write port: o_wr_en/o_wr_data drive the fifo's i_wr_en/i_wr_data, and the fifo's o_full returns as i_full.
- Detects framing errors and fifo overrun, and reports each as a one-cycle pulse.

Parameters:
- ClksPerBit, 868, i_clk cycles per bit period (100 MHz / 115200); must be >= 4.
- DataWidth, 8, data bits per frame, sent LSB first.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rx  input  1  raw serial line, asynchronous to i_clk, idle high.
- i_full  input  1  downstream fifo full flag.
- o_wr_data  output  DataWidth  received word, valid while o_wr_en is high.
- o_wr_en  output  1  one-cycle write strobe to the fifo.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: valid word dropped because i_full was high.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (i_rst_n).
  - Reset forces the state to IDLE and clears all counters and the shift register.
  - All outputs reset to 0. The synchroniser resets to 1 (idle line).
- Synchroniser: i_rx passes through 2 flops to give rx_s.
  - A falling edge is detected when the registered previous rx_s is 1 and rx_s is 0.
- Counters:
  - bit_ctr has width $clog2(ClksPerBit).
  - idx_ctr has width $clog2(DataWidth+1).
- IDLE: on a falling edge of rx_s, go to START with bit_ctr=0.
- START:
  - bit_ctr increments every cycle.
  - At bit_ctr==ClksPerBit/2-1, sample rx_s.
  - If rx_s is 0: go to DATA with bit_ctr=0 and idx_ctr=0.
  - If rx_s is 1: this is a glitch; return to IDLE with no outputs.
- DATA:
  - At bit_ctr==ClksPerBit-1 (mid-bit), shift rx_s into the MSB of shift_reg (right shift, LSB first), reset bit_ctr and increment idx_ctr.
  - After DataWidth samples, go to STOP (PARITY when the option is on).
- STOP: at bit_ctr==ClksPerBit-1, sample rx_s.
  - rx_s 1 and i_full 0: next cycle o_wr_en=1 and o_wr_data=shift_reg; go to IDLE.
  - rx_s 1 and i_full 1: next cycle o_overrun=1 and o_wr_en=0; the word is discarded; go to IDLE.
  - rx_s 0: next cycle o_frame_err=1 with no write; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- o_wr_data holds its last value between strobes.
- End-to-end latency: from the mid-point of the stop bit to o_wr_en is 3 cycles (2 synchroniser cycles + 1 register cycle).
- Back-to-back frames: returning to IDLE at mid-stop lets the next start edge be caught with no lost frame.
- Reset mid-frame: the frame is aborted with no write; after release, the block resynchronises on the next falling edge.
- i_full is sampled only in the STOP decision cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro defined:
  - A PARITY state is inserted between DATA and STOP; rx_s is sampled at bit_ctr==ClksPerBit-1.
  - Even parity is required: XOR of the data bits and the parity bit must be 0.
  - An extra output port o_parity_err (1 bit) is added.
  - On a parity mismatch, the frame still completes its stop check; the word is not written and o_parity_err pulses at the same cycle a write would have occurred.
  - If the stop bit is also bad, frame_err takes priority and parity_err is not pulsed.
- Without the macro: no PARITY state and no o_parity_err port; the frame is 1+DataWidth+1 bits.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_e {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}, where PARITY is unused when the option is off;
  - the default ClksPerBit constant.
- One sub-module: sync_2ff, the parameter-free 2-flop synchroniser with async active-low reset to 1, reusable by other CDC inputs.

Test Plan (bench overrides ClksPerBit=16):
- Reset, then hold i_rx high for 100 cycles -> o_busy=0; o_wr_en, o_frame_err and o_overrun never assert.
- Send 0xA5 (8N1, 16 clk/bit) with i_full=0 -> exactly one o_wr_en pulse with o_wr_data=0xA5, 3 cycles after stop-bit mid-point.
- Send 0x3C then 0xFF back-to-back with no idle gap -> two o_wr_en pulses carrying 0x3C then 0xFF.
- Low glitch of 4 cycles on i_rx -> START aborts, state returns to IDLE, no strobe; a following 0x12 frame is received correctly.
- Send 0x55 with the stop bit forced low, line low for 40 more cycles -> one o_frame_err pulse, no o_wr_en, o_busy high until the line returns high.
- Send 0x81 with i_full=1 -> o_overrun pulse, no o_wr_en. With UART_RX_PARITY_EN, sending 0x07 with parity bit 0 -> o_parity_err pulse and no write.
